// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the burst reader and the attached
// fixed-latency memory.
package mem_pkg;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_READ_DELAY = 3;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with occupancy count. Overflow is prevented
// upstream by credit, so push is not gated here.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/mem_burst_reader.sv
// Burst-read initiator for a fixed-latency RAM: tags each issued read so only
// intended returns enter the credit-protected response FIFO.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_DELAY = DEF_READ_DELAY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [7:0]        i_len_m1,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_read_addr,
  output logic [ADDR_W-1:0] o_mem_write_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_data_ready,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  input  logic              i_rd_ready
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [8:0]            r_remaining;
  logic [READ_DELAY-1:0] r_tag_iss;
  logic [READ_DELAY-1:0] r_tag_last;
  logic                  r_done;

  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic [DATA_W:0]       w_fifo_rd;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_push;
  logic                  w_pop;
  int                    w_inflight;

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < READ_DELAY; i++) w_inflight += int'(r_tag_iss[i]);
  end

  // Credit covers every read whose data may still land in the FIFO.
  assign w_issue      = (r_state == ISSUE) && ((int'(w_fifo_count) + w_inflight) < FIFO_DEPTH);
  assign w_issue_last = w_issue && (r_remaining == 9'd1);
  assign w_push       = r_tag_iss[READ_DELAY-1] && i_mem_data_ready;
  assign w_pop        = o_rd_valid && i_rd_ready;

  assign o_busy           = (r_state != IDLE);
  assign o_done           = r_done;
  assign o_wr_ack         = i_wr_req && (r_state == IDLE);
  assign o_mem_wr_en      = o_wr_ack;
  assign o_mem_write_addr = i_wr_addr;
  assign o_mem_data       = i_wr_data;
  assign o_mem_read_addr  = r_addr;
  assign o_rd_valid       = !w_fifo_empty;
  assign o_rd_data        = w_fifo_rd[DATA_W:1];
  assign o_rd_last        = o_rd_valid && w_fifo_rd[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start && !i_wr_req) begin
          r_state     <= ISSUE;
          r_addr      <= i_base_addr;
          r_remaining <= {1'b0, i_len_m1} + 9'd1;
        end
        ISSUE: if (w_issue) begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - 9'd1;
          if (r_remaining == 9'd1) r_state <= WAIT;
        end
        WAIT: if (w_pop && w_fifo_rd[0]) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_iss  <= '0;
      r_tag_last <= '0;
    end else begin
      for (int i = READ_DELAY-1; i > 0; i--) begin
        r_tag_iss[i]  <= r_tag_iss[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_tag_iss[0]  <= w_issue;
      r_tag_last[0] <= w_issue_last;
    end
  end

`ifndef SYNTHESIS
  // Writes are held off while busy, so a tagged slot must always carry data.
  a_tagged_return_ready: assert property (@(posedge clk) disable iff (rst)
    r_tag_iss[READ_DELAY-1] |-> i_mem_data_ready);
`endif

  resp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({i_mem_data, r_tag_last[READ_DELAY-1]}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rd),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );
endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: fixed-latency memory stub, stream monitor and a
// reference memory image from which every expected burst is derived.
module tb_mem_burst_reader;
  import mem_pkg::*;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int RD = DEF_READ_DELAY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [7:0]    i_len_m1 = '0;
  logic          o_busy, o_done;
  logic          i_wr_req = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ack, o_mem_wr_en;
  logic [AW-1:0] o_mem_read_addr, o_mem_write_addr;
  logic [DW-1:0] o_mem_data;
  logic          i_mem_data_ready;
  logic [DW-1:0] i_mem_data;
  logic          o_rd_valid, o_rd_last;
  logic [DW-1:0] o_rd_data;
  logic          i_rd_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;

  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] pipe_d [RD];
  logic          pipe_v [RD];

  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int first_valid_cyc = -1;
  int last_pop_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;

  mem_burst_reader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len_m1(i_len_m1), .o_busy(o_busy), .o_done(o_done),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_read_addr(o_mem_read_addr), .o_mem_write_addr(o_mem_write_addr),
    .o_mem_data(o_mem_data), .i_mem_data_ready(i_mem_data_ready),
    .i_mem_data(i_mem_data), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_rd_last(o_rd_last), .i_rd_ready(i_rd_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory stub: returns mem[read_addr] RD cycles later on every non-write cycle.
  always @(posedge clk) begin
    if (o_mem_wr_en) mem_arr[o_mem_write_addr] <= o_mem_data;
    pipe_d[0] <= mem_arr[o_mem_read_addr];
    pipe_v[0] <= !o_mem_wr_en;
    for (int i = 1; i < RD; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign i_mem_data       = pipe_d[RD-1];
  assign i_mem_data_ready = pipe_v[RD-1];

  always @(posedge clk) begin
    #1;
    i_rd_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
  end

  always @(negedge clk) begin
    if (o_rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_rd_valid && i_rd_ready) begin
      got_d.push_back(o_rd_data);
      got_l.push_back(o_rd_last);
      if (o_rd_last) last_pop_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [DW-1:0] data);
    bit acked = 0;
    i_wr_req = 1'b1; i_wr_addr = addr; i_wr_data = data;
    for (int n = 0; n < 2000 && !acked; n++) begin
      @(negedge clk);
      acked = o_wr_ack;
      tick();
    end
    i_wr_req = 1'b0;
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL write_ack: no ack for addr %0h, required ack", addr);
    end
    ref_mem[addr] = data;
  endtask

  task automatic start_burst(input logic [7:0] base, input logic [7:0] len_m1, output int s);
    bit ok = 0;
    i_start = 1'b1; i_base_addr = base; i_len_m1 = len_m1;
    s = -1;
    for (int n = 0; n < 200 && !ok; n++) begin
      tick();
      if (o_busy) begin
        ok = 1;
        s = cyc - 1;
      end
    end
    i_start = 1'b0;
    i_base_addr = 8'($urandom);
    i_len_m1 = 8'($urandom);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_accept: o_busy=0 after 200 cycles, required 1");
    end
  endtask

  task automatic wait_done(input int d0, input int limit, input string name);
    bit ok = 0;
    for (int n = 0; n < limit && !ok; n++) begin
      tick();
      if (done_cnt > d0) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done_timeout: done_cnt=%0d required >%0d", name, done_cnt, d0);
    end
  endtask

  task automatic check_stream(input logic [7:0] base, input logic [7:0] len_m1,
                              input int d0, input string name);
    int n = int'(len_m1) + 1;
    logic [DW-1:0] exp_d;
    checks++;
    if (got_d.size() != n) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats, required %0d", name, got_d.size(), n);
    end
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      exp_d = ref_mem[(int'(base) + i) % 256];
      checks++;
      if (got_d[i] !== exp_d || got_l[i] !== (i == n - 1)) begin
        errors++;
        $display("FAIL %s_beat%0d: got data %08h last %0b, required data %08h last %0b",
                 name, i, got_d[i], got_l[i], exp_d, (i == n - 1));
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_cnt - d0);
    end
    checks++;
    if (done_cyc != last_pop_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: done cycle %0d, required %0d", name, done_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    first_valid_cyc = -1;
  endtask

  task automatic run_burst(input logic [7:0] base, input logic [7:0] len_m1,
                           input string name, output int s);
    int d0;
    clear_mon();
    d0 = done_cnt;
    start_burst(base, len_m1, s);
    wait_done(d0, 3000, name);
    repeat (3) tick();
    check_stream(base, len_m1, d0, name);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rd_valid !== 1'b0 || o_rd_last !== 1'b0 ||
        o_mem_wr_en !== 1'b0 || o_mem_read_addr !== 8'h00) begin
      errors++;
      $display("FAIL %s: got busy %0b done %0b valid %0b last %0b wr_en %0b raddr %0h, required all 0",
               name, o_busy, o_done, o_rd_valid, o_rd_last, o_mem_wr_en, o_mem_read_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_idle_outputs("reset_values");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_idle_outputs("after_reset");
  endtask

  task automatic test_write_burst();
    int s;
    for (int i = 0; i < 4; i++) do_write(8'(8'h10 + i), 32'(32'hA0 + i));
    ready_mode = 1;
    run_burst(8'h10, 8'd3, "basic", s);
    checks++;
    if (first_valid_cyc != s + 5) begin
      errors++;
      $display("FAIL first_valid_latency: got cycle %0d, required %0d", first_valid_cyc, s + 5);
    end
  endtask

  task automatic test_wrap();
    int s;
    do_write(8'hFE, 32'h0000_F0FE);
    do_write(8'hFF, 32'h0000_F0FF);
    do_write(8'h00, 32'h0000_F000);
    do_write(8'h01, 32'h0000_F001);
    run_burst(8'hFE, 8'd3, "wrap", s);
  endtask

  task automatic test_stall();
    int s, d0;
    ready_mode = 0;
    repeat (2) tick();
    clear_mon();
    d0 = done_cnt;
    start_burst(8'h20, 8'd255, s);
    repeat (20) tick();
    checks++;
    if (o_mem_read_addr !== 8'h28 || o_rd_valid !== 1'b1 || got_d.size() != 0) begin
      errors++;
      $display("FAIL stall_credit: raddr %0h valid %0b popped %0d, required raddr 28 valid 1 popped 0",
               o_mem_read_addr, o_rd_valid, got_d.size());
    end
    ready_mode = 1;
    wait_done(d0, 3000, "stall");
    repeat (3) tick();
    check_stream(8'h20, 8'd255, d0, "stall");
  endtask

  task automatic test_write_during_burst();
    int s, d0, ack_cyc = -1;
    bit bad = 0;
    logic [DW-1:0] wdata = 32'hDEAD_BEEF;
    ready_mode = 1;
    clear_mon();
    d0 = done_cnt;
    start_burst(8'h40, 8'd15, s);
    i_start = 1'b1; i_base_addr = 8'h99; i_len_m1 = 8'd0;
    i_wr_req = 1'b1; i_wr_addr = 8'h41; i_wr_data = wdata;
    for (int n = 0; n < 2000 && ack_cyc < 0; n++) begin
      @(negedge clk);
      if (o_busy && (o_wr_ack || o_mem_wr_en)) bad = 1;
      if (o_wr_ack) ack_cyc = cyc;
      tick();
      if (n == 2) i_start = 1'b0;
    end
    i_wr_req = 1'b0;
    i_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_write_blocked: ack/wr_en seen while busy, required 0");
    end
    checks++;
    if (ack_cyc < 0 || ack_cyc != done_cyc) begin
      errors++;
      $display("FAIL deferred_write_ack: ack cycle %0d, required %0d", ack_cyc, done_cyc);
    end
    check_stream(8'h40, 8'd15, d0, "busy_write");
    ref_mem[8'h41] = wdata;
    run_burst(8'h41, 8'd0, "readback", s);
  endtask

  task automatic test_start_and_write();
    int d0;
    ready_mode = 1;
    clear_mon();
    d0 = done_cnt;
    i_start = 1'b1; i_base_addr = 8'h50; i_len_m1 = 8'd1;
    i_wr_req = 1'b1; i_wr_addr = 8'h50; i_wr_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (o_wr_ack !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_priority: ack %0b busy %0b, required ack 1 busy 0", o_wr_ack, o_busy);
    end
    tick();
    i_wr_req = 1'b0;
    ref_mem[8'h50] = 32'h1234_5678;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_deferred: busy %0b, required 0", o_busy);
    end
    tick();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_write: busy %0b, required 1", o_busy);
    end
    wait_done(d0, 1000, "start_write");
    repeat (3) tick();
    check_stream(8'h50, 8'd1, d0, "start_write");
  endtask

  task automatic test_reset_mid_burst();
    int s, d0, g0;
    ready_mode = 1;
    clear_mon();
    start_burst(8'h60, 8'd7, s);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_burst");
    tick();
    rst = 1'b0;
    g0 = got_d.size();
    d0 = done_cnt;
    repeat (15) tick();
    checks++;
    if (got_d.size() != g0 || done_cnt != d0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: beats %0d done %0d busy %0b, required beats %0d done %0d busy 0",
               got_d.size(), done_cnt, o_busy, g0, d0);
    end
    run_burst(8'h60, 8'd7, "after_reset", s);
  endtask

  task automatic test_random();
    int s;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 3; w++) do_write(8'($urandom), $urandom);
      ready_mode = (k % 2 == 0) ? 2 : 1;
      run_burst(8'($urandom), 8'($urandom_range(0, 40)), "random", s);
    end
    ready_mode = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    for (int i = 0; i < RD; i++) begin
      pipe_d[i] = '0;
      pipe_v[i] = 1'b0;
    end
    test_reset();
    test_write_burst();
    test_wrap();
    test_stall();
    test_write_during_burst();
    test_start_and_write();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
